// File: rtl/ahb_lite_pkg.sv
// Shared AHB-Lite encodings and enumerations for the single-master fabric.
// Used by the address decoder and by the response multiplexer.
package ahb_lite_pkg;

  localparam int BUS_WIDTH      = 32;
  localparam int AHB_NUM_SLAVES = 4;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_S0,
    SEL_S1,
    SEL_S2,
    SEL_S3,
    SEL_DEF
  } sel_e;

  typedef enum logic [1:0] {
    DS_IDLE,
    DS_ERR1,
    DS_ERR2
  } ds_state_e;

  // NONSEQ/SEQ carry a real transfer; IDLE/BUSY never reach the default slave.
  function automatic logic htrans_active(input logic [1:0] trans);
    case (trans)
      HTRANS_NONSEQ, HTRANS_SEQ: return 1'b1;
      HTRANS_IDLE, HTRANS_BUSY:  return 1'b0;
      default:                   return 1'b0;
    endcase
  endfunction

  function automatic sel_e slave_sel(input int idx);
    case (idx)
      0:       return SEL_S0;
      1:       return SEL_S1;
      2:       return SEL_S2;
      default: return SEL_S3;
    endcase
  endfunction

endpackage

// File: rtl/ahb_lite_default_slave.sv
// Default slave for unmapped addresses: answers every active transfer with
// the two-cycle ERROR response (ERR1 stalls, ERR2 completes).
module ahb_lite_default_slave
  import ahb_lite_pkg::*;
(
  input  logic HCLK,
  input  logic HRESETn,
  input  logic sel,
  input  logic HREADY,
  output logic HREADYOUT,
  output logic HRESP
);

  ds_state_e state_q, state_d;

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q <= DS_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    HREADYOUT = 1'b1;
    HRESP     = HRESP_OKAY;
    case (state_q)
      DS_IDLE: begin
        if (sel && HREADY) state_d = DS_ERR1;
      end
      DS_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = HRESP_ERROR;
        state_d   = DS_ERR2;
      end
      DS_ERR2: begin
        HRESP   = HRESP_ERROR;
        // A new unmapped phase accepted here restarts the pair without a gap.
        state_d = (sel && HREADY) ? DS_ERR1 : DS_IDLE;
      end
      default: state_d = DS_IDLE;
    endcase
  end

endmodule

// File: rtl/ahb_lite_resp_mux.sv
// Data-phase response mux: latches the decoder's slave select at each accepted
// address phase and routes that slave's response back to the master.
module ahb_lite_resp_mux
  import ahb_lite_pkg::*;
#(
  parameter int DATA_WIDTH = BUS_WIDTH,
  parameter int NUM_SLAVES = AHB_NUM_SLAVES
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL0,
  input  logic                  HSEL1,
  input  logic                  HSEL2,
  input  logic                  HSEL3,
  input  logic [1:0]            HTRANS,
  input  logic [DATA_WIDTH-1:0] HRDATA0,
  input  logic [DATA_WIDTH-1:0] HRDATA1,
  input  logic [DATA_WIDTH-1:0] HRDATA2,
  input  logic [DATA_WIDTH-1:0] HRDATA3,
  input  logic                  HREADYOUT0,
  input  logic                  HREADYOUT1,
  input  logic                  HREADYOUT2,
  input  logic                  HREADYOUT3,
  input  logic                  HRESP0,
  input  logic                  HRESP1,
  input  logic                  HRESP2,
  input  logic                  HRESP3,
  output logic [DATA_WIDTH-1:0] HRDATA,
  output logic                  HREADY,
  output logic                  HRESP
);

  logic [DATA_WIDTH-1:0] s_rdata [NUM_SLAVES];
  logic [NUM_SLAVES-1:0] s_hsel;
  logic [NUM_SLAVES-1:0] s_ready;
  logic [NUM_SLAVES-1:0] s_resp;
  logic [NUM_SLAVES-1:0] s_active;

  sel_e sel_q, sel_d;
  logic hsel_def;
  logic ds_ready;
  logic ds_resp;

  assign s_hsel     = {HSEL3, HSEL2, HSEL1, HSEL0};
  assign s_ready    = {HREADYOUT3, HREADYOUT2, HREADYOUT1, HREADYOUT0};
  assign s_resp     = {HRESP3, HRESP2, HRESP1, HRESP0};
  assign s_rdata[0] = HRDATA0;
  assign s_rdata[1] = HRDATA1;
  assign s_rdata[2] = HRDATA2;
  assign s_rdata[3] = HRDATA3;

  assign hsel_def = ~|s_hsel && htrans_active(HTRANS);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLAVES; gi++) begin : g_active
      assign s_active[gi] = (sel_q == slave_sel(gi));
    end
  endgenerate

  // Lowest-numbered HSEL wins when the decoder asserts more than one.
  always_comb begin
    sel_d = sel_q;
    if (HREADY) begin
      sel_d = hsel_def ? SEL_DEF : SEL_NONE;
      for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
        if (s_hsel[i]) sel_d = slave_sel(i);
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      sel_q <= SEL_NONE;
    end else begin
      sel_q <= sel_d;
    end
  end

  ahb_lite_default_slave u_default_slave (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .sel       (hsel_def),
    .HREADY    (HREADY),
    .HREADYOUT (ds_ready),
    .HRESP     (ds_resp)
  );

  always_comb begin
    HRDATA = '0;
    HREADY = 1'b1;
    HRESP  = HRESP_OKAY;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (s_active[i]) begin
        HRDATA = s_rdata[i];
        HREADY = s_ready[i];
        HRESP  = s_resp[i];
      end
    end
    if (sel_q == SEL_DEF) begin
      HREADY = ds_ready;
      HRESP  = ds_resp;
    end
  end

endmodule

// File: tb/tb_ahb_lite_resp_mux.sv
// Directed bench for ahb_lite_resp_mux: the driver queues the required response
// for every cycle, a negedge monitor pops and compares against the DUT outputs.
module tb_ahb_lite_resp_mux;

  logic        HCLK;
  logic        HRESETn;
  logic        HSEL0, HSEL1, HSEL2, HSEL3;
  logic [1:0]  HTRANS;
  logic [31:0] HRDATA0, HRDATA1, HRDATA2, HRDATA3;
  logic        HREADYOUT0, HREADYOUT1, HREADYOUT2, HREADYOUT3;
  logic        HRESP0, HRESP1, HRESP2, HRESP3;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;

  localparam logic [1:0] T_IDLE   = 2'b00;
  localparam logic [1:0] T_BUSY   = 2'b01;
  localparam logic [1:0] T_NONSEQ = 2'b10;
  localparam logic [1:0] T_SEQ    = 2'b11;

  localparam logic [31:0] D0 = 32'h0000_F00D;
  localparam logic [31:0] D1 = 32'hDEAD_BEEF;
  localparam logic [31:0] D2 = 32'h2222_2222;
  localparam logic [31:0] D3 = 32'h3333_3333;

  typedef struct {
    logic [31:0] rdata;
    logic        ready;
    logic        resp;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    vectors = 0;
  int    miscompares = 0;

  ahb_lite_resp_mux dut (
    .HCLK       (HCLK),
    .HRESETn    (HRESETn),
    .HSEL0      (HSEL0),
    .HSEL1      (HSEL1),
    .HSEL2      (HSEL2),
    .HSEL3      (HSEL3),
    .HTRANS     (HTRANS),
    .HRDATA0    (HRDATA0),
    .HRDATA1    (HRDATA1),
    .HRDATA2    (HRDATA2),
    .HRDATA3    (HRDATA3),
    .HREADYOUT0 (HREADYOUT0),
    .HREADYOUT1 (HREADYOUT1),
    .HREADYOUT2 (HREADYOUT2),
    .HREADYOUT3 (HREADYOUT3),
    .HRESP0     (HRESP0),
    .HRESP1     (HRESP1),
    .HRESP2     (HRESP2),
    .HRESP3     (HRESP3),
    .HRDATA     (HRDATA),
    .HREADY     (HREADY),
    .HRESP      (HRESP)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  // Drives one cycle's inputs just after the edge and queues that cycle's response.
  task automatic cyc(input logic rst_n, input logic [3:0] hsel, input logic [1:0] trans,
                     input logic [3:0] rdyo, input logic [3:0] resp,
                     input logic [31:0] e_rdata, input logic e_ready, input logic e_resp,
                     input string nm);
    exp_t e;
    HRESETn = rst_n;
    {HSEL3, HSEL2, HSEL1, HSEL0} = hsel;
    HTRANS = trans;
    {HREADYOUT3, HREADYOUT2, HREADYOUT1, HREADYOUT0} = rdyo;
    {HRESP3, HRESP2, HRESP1, HRESP0} = resp;
    e.rdata = e_rdata;
    e.ready = e_ready;
    e.resp  = e_resp;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge HCLK);
    #1;
  endtask

  always @(negedge HCLK) begin
    if (exp_q.size() > 0) begin
      exp_t  e;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      vectors++;
      if (HRDATA !== e.rdata || HREADY !== e.ready || HRESP !== e.resp) begin
        miscompares++;
        $display("FAIL %s: got HRDATA=%h HREADY=%b HRESP=%b, required HRDATA=%h HREADY=%b HRESP=%b",
                 nm, HRDATA, HREADY, HRESP, e.rdata, e.ready, e.resp);
      end else begin
        $display("vec %0d %s: HRDATA=%h HREADY=%b HRESP=%b ok", vectors, nm, HRDATA, HREADY, HRESP);
      end
    end
  end

  initial begin
    HRESETn = 1'b0;
    {HSEL3, HSEL2, HSEL1, HSEL0} = 4'h0;
    HTRANS = T_IDLE;
    {HREADYOUT3, HREADYOUT2, HREADYOUT1, HREADYOUT0} = 4'hF;
    {HRESP3, HRESP2, HRESP1, HRESP0} = 4'h0;
    HRDATA0 = $urandom; HRDATA1 = $urandom; HRDATA2 = $urandom; HRDATA3 = $urandom;
    @(posedge HCLK);
    #1;

    // Reset with random slave activity, then the first cycle after release
    cyc(1'b0, 4'($urandom), 2'($urandom), 4'($urandom), 4'($urandom), 32'h0, 1'b1, 1'b0, "rst_c0");
    cyc(1'b0, 4'($urandom), 2'($urandom), 4'($urandom), 4'($urandom), 32'h0, 1'b1, 1'b0, "rst_c1");
    cyc(1'b1, 4'h0, T_IDLE, 4'($urandom), 4'($urandom), 32'h0, 1'b1, 1'b0, "rst_release");
    HRDATA0 = D0; HRDATA1 = D1; HRDATA2 = D2; HRDATA3 = D3;

    // Single read from slave 1
    cyc(1'b1, 4'b0010, T_NONSEQ, 4'hF, 4'h0, 32'h0, 1'b1, 1'b0, "rd_addr");
    cyc(1'b1, 4'b0000, T_IDLE,   4'hF, 4'h0, D1,    1'b1, 1'b0, "rd_data");

    // Slave 2 with three wait states while slave 0 is pending in the address phase
    cyc(1'b1, 4'b0100, T_NONSEQ, 4'hF,    4'h0, 32'h0, 1'b1, 1'b0, "ws_addr");
    cyc(1'b1, 4'b0001, T_NONSEQ, 4'b1011, 4'h0, D2,    1'b0, 1'b0, "ws_wait0");
    cyc(1'b1, 4'b0001, T_NONSEQ, 4'b1011, 4'h0, D2,    1'b0, 1'b0, "ws_wait1");
    cyc(1'b1, 4'b0001, T_NONSEQ, 4'b1011, 4'h0, D2,    1'b0, 1'b0, "ws_wait2");
    cyc(1'b1, 4'b0001, T_NONSEQ, 4'hF,    4'h0, D2,    1'b1, 1'b0, "ws_done");
    cyc(1'b1, 4'b0000, T_IDLE,   4'hF,    4'h0, D0,    1'b1, 1'b0, "ws_s0");

    // Single unmapped access
    cyc(1'b1, 4'h0, T_NONSEQ, 4'hF, 4'h0, 32'h0, 1'b1, 1'b0, "um_addr");
    cyc(1'b1, 4'h0, T_IDLE,   4'hF, 4'h0, 32'h0, 1'b0, 1'b1, "um_err1");
    cyc(1'b1, 4'h0, T_IDLE,   4'hF, 4'h0, 32'h0, 1'b1, 1'b1, "um_err2");
    cyc(1'b1, 4'h0, T_IDLE,   4'hF, 4'h0, 32'h0, 1'b1, 1'b0, "um_okay");

    // Back-to-back unmapped NONSEQ then SEQ
    cyc(1'b1, 4'h0, T_NONSEQ, 4'hF, 4'h0, 32'h0, 1'b1, 1'b0, "b2b_addr");
    cyc(1'b1, 4'h0, T_SEQ,    4'hF, 4'h0, 32'h0, 1'b0, 1'b1, "b2b_err1a");
    cyc(1'b1, 4'h0, T_SEQ,    4'hF, 4'h0, 32'h0, 1'b1, 1'b1, "b2b_err2a");
    cyc(1'b1, 4'h0, T_IDLE,   4'hF, 4'h0, 32'h0, 1'b0, 1'b1, "b2b_err1b");
    cyc(1'b1, 4'h0, T_IDLE,   4'hF, 4'h0, 32'h0, 1'b1, 1'b1, "b2b_err2b");
    cyc(1'b1, 4'h0, T_BUSY,   4'hF, 4'h0, 32'h0, 1'b1, 1'b0, "b2b_okay");
    cyc(1'b1, 4'h0, T_IDLE,   4'hF, 4'h0, 32'h0, 1'b1, 1'b0, "busy_no_err");
    cyc(1'b1, 4'h0, T_IDLE,   4'hF, 4'h0, 32'h0, 1'b1, 1'b0, "idle_no_err");

    // Reset asserted at the edge ending DS_ERR1
    cyc(1'b1, 4'h0, T_NONSEQ, 4'hF, 4'h0, 32'h0, 1'b1, 1'b0, "rerr_addr");
    cyc(1'b0, 4'h0, T_IDLE,   4'hF, 4'h0, 32'h0, 1'b0, 1'b1, "rerr_err1");
    cyc(1'b1, 4'h0, T_IDLE,   4'hF, 4'h0, 32'h0, 1'b1, 1'b0, "rerr_after");
    cyc(1'b1, 4'h0, T_IDLE,   4'hF, 4'h0, 32'h0, 1'b1, 1'b0, "rerr_idle");

    // Slave 3 two-cycle ERROR passed through unchanged
    cyc(1'b1, 4'b1000, T_NONSEQ, 4'hF,    4'h0,    32'h0, 1'b1, 1'b0, "s3err_addr");
    cyc(1'b1, 4'b0000, T_IDLE,   4'b0111, 4'b1000, D3,    1'b0, 1'b1, "s3err_c1");
    cyc(1'b1, 4'b0000, T_IDLE,   4'hF,    4'b1000, D3,    1'b1, 1'b1, "s3err_c2");
    cyc(1'b1, 4'b0000, T_IDLE,   4'hF,    4'b1000, 32'h0, 1'b1, 1'b0, "s3err_none");

    // Slave-to-slave without a bubble, then multi-HSEL priority
    cyc(1'b1, 4'b0001, T_NONSEQ, 4'hF, 4'h0, 32'h0, 1'b1, 1'b0, "s2s_a0");
    cyc(1'b1, 4'b1000, T_NONSEQ, 4'hF, 4'h0, D0,    1'b1, 1'b0, "s2s_d0_a3");
    cyc(1'b1, 4'b0110, T_BUSY,   4'hF, 4'h0, D3,    1'b1, 1'b0, "s2s_d3_prio");
    cyc(1'b1, 4'b0000, T_IDLE,   4'hF, 4'h0, D1,    1'b1, 1'b0, "prio_s1");
    cyc(1'b1, 4'b0000, T_IDLE,   4'hF, 4'h0, 32'h0, 1'b1, 1'b0, "final_none");

    repeat (2) @(negedge HCLK);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d responses left unchecked, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
